instr_fetch: RTL and testbench

Fetch stage feeding the instruction memory. Holds the program counter and drives the byte address ProgCounter into the instruction memory. Captures the word returned in the same cycle into the IF/ID pipeline register. Handles stalls, redirects from ID-stage branch/jump resolution, and a halt state.

---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage and its neighbours: instruction memory,
// ID-stage redirect sources, the hazard unit and the IF/ID pipeline register.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 10
);
    logic [PC_WIDTH-1:0] ProgCounter;
    logic [31:0]         Instr;
    logic                Stall;
    logic                BranchTaken;
    logic [15:0]         BranchOffset;
    logic                Jump;
    logic [25:0]         JumpTarget;
    logic                JumpReg;
    logic [31:0]         RegTarget;
    logic [31:0]         IfIdInstr;
    logic [PC_WIDTH-1:0] IfIdPC4;
    logic                IfIdValid;
    logic                Halted;
    logic                AlignErr;
    logic [15:0]         FetchCount;

    modport master (
        output ProgCounter, IfIdInstr, IfIdPC4, IfIdValid, Halted, AlignErr, FetchCount,
        input  Instr, Stall, BranchTaken, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget
    );

    modport slave (
        input  ProgCounter, IfIdInstr, IfIdPC4, IfIdValid, Halted, AlignErr, FetchCount,
        output Instr, Stall, BranchTaken, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, captures instruction memory data into IF/ID,
// and handles stalls, ID-stage redirects and the syscall halt.
module instr_fetch #(
    parameter int                  PC_WIDTH  = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         HALT_WORD = 32'h0000000C
) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t              state;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_target;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [31:0]         branch_offset_ext;
    logic [27:0]         jump_full;
    logic                unused_bits;

    assign redirect          = bus.JumpReg | bus.Jump | bus.BranchTaken;
    assign pc_plus4          = bus.ProgCounter + PC_WIDTH'(4);
    assign branch_offset_ext = {{14{bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
    assign jump_full         = {bus.JumpTarget, 2'b00};
    assign unused_bits       = ^{bus.RegTarget[31:PC_WIDTH], bus.RegTarget[1:0],
                                 jump_full[27:PC_WIDTH], branch_offset_ext[31:PC_WIDTH]};

    // jr outranks j, which outranks a taken branch
    always_comb begin
        redirect_target = '0;
        if (bus.JumpReg)
            redirect_target = {bus.RegTarget[PC_WIDTH-1:2], 2'b00};
        else if (bus.Jump)
            redirect_target = jump_full[PC_WIDTH-1:0];
        else if (bus.BranchTaken)
            redirect_target = bus.IfIdPC4 + branch_offset_ext[PC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            bus.ProgCounter <= RESET_PC;
            bus.IfIdInstr   <= '0;
            bus.IfIdPC4     <= '0;
            bus.IfIdValid   <= 1'b0;
            bus.Halted      <= 1'b0;
            bus.AlignErr    <= 1'b0;
            bus.FetchCount  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        // Wrong-path fetch is squashed; redirect wins even over a stall
                        bus.ProgCounter <= redirect_target;
                        bus.IfIdInstr   <= '0;
                        bus.IfIdPC4     <= '0;
                        bus.IfIdValid   <= 1'b0;
                        if (bus.JumpReg && (bus.RegTarget[1:0] != 2'b00))
                            bus.AlignErr <= 1'b1;
                    end else if (!bus.Stall) begin
                        bus.IfIdInstr <= bus.Instr;
                        bus.IfIdPC4   <= pc_plus4;
                        bus.IfIdValid <= 1'b1;
                        if (bus.FetchCount != 16'hFFFF)
                            bus.FetchCount <= bus.FetchCount + 16'd1;
                        if (bus.Instr == HALT_WORD) begin
                            state      <= HALT;
                            bus.Halted <= 1'b1;
                        end else begin
                            bus.ProgCounter <= pc_plus4;
                        end
                    end
                end
                HALT: begin
                    bus.IfIdInstr <= '0;
                    bus.IfIdPC4   <= '0;
                    bus.IfIdValid <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a reference model predicts each cycle's
// outputs into a scoreboard queue that is drained after every clock edge.
module tb_instr_fetch;
    localparam int PW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(PW)) bus ();

    instr_fetch #(.PC_WIDTH(PW), .RESET_PC('0), .HALT_WORD(32'h0000000C)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] mem [0:255];
    assign bus.Instr = mem[bus.ProgCounter[9:2]];

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [31:0]   instr;
        logic [PW-1:0] pc4;
        logic          valid;
        logic          halted;
        logic          align;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb[$];

    logic [PW-1:0] m_pc, m_pc4;
    logic [31:0]   m_instr;
    logic          m_valid, m_halted, m_align;
    logic [15:0]   m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle, predict its result, then compare after the edge
    task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                                 input logic [15:0] off, input logic j, input logic [25:0] jt,
                                 input logic jr, input logic [31:0] rt);
        logic [31:0] fetched;
        exp_t e, got;
        @(negedge clk);
        reset            = rst;
        bus.Stall        = stall;
        bus.BranchTaken  = br;
        bus.BranchOffset = off;
        bus.Jump         = j;
        bus.JumpTarget   = jt;
        bus.JumpReg      = jr;
        bus.RegTarget    = rt;

        fetched = mem[m_pc[9:2]];
        if (rst) begin
            m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 0;
            m_halted = 0; m_align = 0; m_cnt = '0;
        end else if (m_halted) begin
            m_instr = '0; m_pc4 = '0; m_valid = 0;
        end else if (jr || j || br) begin
            if (jr) begin
                m_pc = PW'(rt & 32'h3FC);
                if (rt[1:0] != 2'b00) m_align = 1;
            end else if (j) begin
                m_pc = PW'(int'(jt) * 4);
            end else begin
                m_pc = PW'(int'(m_pc4) + 4 * int'($signed(off)));
            end
            m_instr = '0; m_pc4 = '0; m_valid = 0;
        end else if (!stall) begin
            m_instr = fetched;
            m_pc4   = PW'(int'(m_pc) + 4);
            m_valid = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (fetched == 32'h0000000C) m_halted = 1;
            else m_pc = m_pc4;
        end
        sb.push_back('{m_pc, m_instr, m_pc4, m_valid, m_halted, m_align, m_cnt});

        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = '{bus.ProgCounter, bus.IfIdInstr, bus.IfIdPC4, bus.IfIdValid,
                bus.Halted, bus.AlignErr, bus.FetchCount};
        checkOutput("ProgCounter", 32'(got.pc), 32'(e.pc));
        checkOutput("IfIdInstr", got.instr, e.instr);
        checkOutput("IfIdPC4", 32'(got.pc4), 32'(e.pc4));
        checkOutput("IfIdValid", 32'(got.valid), 32'(e.valid));
        checkOutput("Halted", 32'(got.halted), 32'(e.halted));
        checkOutput("AlignErr", 32'(got.align), 32'(e.align));
        checkOutput("FetchCount", 32'(got.cnt), 32'(e.cnt));
    endtask

    task automatic fetchCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i << 4);
        mem[4] = 32'h0000000C;

        reset = 1'b1;
        bus.Stall = 0; bus.BranchTaken = 0; bus.BranchOffset = '0;
        bus.Jump = 0; bus.JumpTarget = '0; bus.JumpReg = 0; bus.RegTarget = '0;

        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        checkOutput("reset_pc", 32'(bus.ProgCounter), 32'h0);

        // Straight line, then a two-cycle stall at PC=8
        fetchCycles(1);
        checkOutput("first_instr", bus.IfIdInstr, 32'hA000_0000);
        checkOutput("first_pc4", 32'(bus.IfIdPC4), 32'h4);
        fetchCycles(1);
        applyStimulus(0, 1, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 1, 0, '0, 0, '0, 0, '0);
        checkOutput("stall_pc", 32'(bus.ProgCounter), 32'h8);
        fetchCycles(2);
        checkOutput("pc4_before_branch", 32'(bus.IfIdPC4), 32'h10);

        // Taken branch back by two words squashes the halt word at 0x10
        applyStimulus(0, 0, 1, 16'hFFFE, 0, '0, 0, '0);
        checkOutput("branch_pc", 32'(bus.ProgCounter), 32'h8);
        fetchCycles(2);
        applyStimulus(0, 1, 1, 16'hFFFE, 0, '0, 0, '0);
        checkOutput("branch_stall_pc", 32'(bus.ProgCounter), 32'h8);
        fetchCycles(1);

        // jr and j together: jr wins, misaligned target flags AlignErr
        applyStimulus(0, 0, 0, '0, 1, 26'd5, 1, 32'h0000_0102);
        checkOutput("jr_pc", 32'(bus.ProgCounter), 32'h100);
        fetchCycles(3);
        checkOutput("align_sticky", 32'(bus.AlignErr), 32'h1);

        // Jump to the top word and wrap
        applyStimulus(0, 0, 0, '0, 1, 26'hFF, 0, '0);
        fetchCycles(1);
        checkOutput("wrap_pc", 32'(bus.ProgCounter), 32'h0);
        checkOutput("wrap_pc4", 32'(bus.IfIdPC4), 32'h0);

        // Reach the halt word, hold it under stall, then let it halt
        fetchCycles(4);
        applyStimulus(0, 1, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 1, 0, '0, 0, '0, 0, '0);
        checkOutput("no_halt_in_stall", 32'(bus.Halted), 32'h0);
        fetchCycles(1);
        checkOutput("halt_instr", bus.IfIdInstr, 32'h0000000C);
        checkOutput("halted", 32'(bus.Halted), 32'h1);
        applyStimulus(0, 0, 1, 16'h0004, 0, '0, 0, '0);
        checkOutput("halt_pc", 32'(bus.ProgCounter), 32'h10);
        applyStimulus(0, 0, 0, '0, 1, 26'd3, 1, 32'h0000_0041);
        fetchCycles(2);

        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        checkOutput("reset_halted", 32'(bus.Halted), 32'h0);
        checkOutput("reset_align", 32'(bus.AlignErr), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 80; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 99));
            applyStimulus(($urandom_range(0, 49) == 0),
                          (r < 20),
                          (r >= 20 && r < 28),
                          16'($urandom_range(0, 15)) - 16'd8,
                          (r >= 28 && r < 32),
                          26'($urandom),
                          (r >= 32 && r < 36),
                          $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
